// File: rtl/multicycle_processor_pkg.sv
// Shared constant library for the multicycle core: opcodes, funct codes,
// ALU control codes, FSM state encoding and small decode helpers.
// Optional feature macro: MCP_BNE_EN (adds bne, opcode 0x05).
package multicycle_processor_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
`ifdef MCP_BNE_EN
  localparam logic [5:0] OpBne   = 6'h05;
`endif
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {
    AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluNone
  } alu_op_e;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExecute, StMemory, StWriteback, StHalt
  } state_e;

  // Opcodes the core can execute; anything else halts from DECODE.
  function automatic logic opcode_legal(input logic [5:0] op);
    case (op)
      OpRtype, OpJ, OpBeq, OpAddi, OpLw, OpSw: return 1'b1;
`ifdef MCP_BNE_EN
      OpBne: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // AluNone marks an unsupported R-type funct.
  function automatic alu_op_e funct_to_alu(input logic [5:0] fn);
    case (fn)
      FnAdd:   return AluAdd;
      FnSub:   return AluSub;
      FnAnd:   return AluAnd;
      FnOr:    return AluOr;
      FnSlt:   return AluSlt;
      default: return AluNone;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_processor_if.sv
// Memory bus between the multicycle core (master) and memory (slave).
// Request is held until mem_ready; ready may coincide with the request.
interface multicycle_processor_if #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_SIZE-1:0]  mem_wdata;
  logic                  mem_ready;
  logic [WORD_SIZE-1:0]  mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mcp_regfile.sv
// 32-entry register file: two asynchronous read ports, one synchronous write
// port, asynchronous active-low clear. Register 0 reads as zero and ignores writes.
module mcp_regfile #(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rd_addr_a,
  input  logic [4:0]           rd_addr_b,
  output logic [WORD_SIZE-1:0] rd_data_a,
  output logic [WORD_SIZE-1:0] rd_data_b,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data
);

  logic [WORD_SIZE-1:0] regs_q [32];

  // Storage: cleared on reset, written at the clock edge when enabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == 5'd0) ? '0 : regs_q[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 5'd0) ? '0 : regs_q[rd_addr_b];

endmodule

// File: rtl/multicycle_processor.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT.
// Optional feature macro: MCP_BNE_EN (bne, opcode 0x05, timed as beq).
module multicycle_processor
  import multicycle_processor_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_processor_if.master mem,
  output logic [WORD_SIZE-1:0]  prog_count,
  output logic [5:0]            instr_opcode,
  output logic                  write_reg_en,
  output logic [4:0]            write_reg_addr,
  output logic [WORD_SIZE-1:0]  write_reg_data,
  output logic                  halted
);

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] pc_q, pc_d;
  logic [31:0]          ir_q, ir_d;
  logic [WORD_SIZE-1:0] a_q, a_d, b_q, b_d;
  logic [WORD_SIZE-1:0] alu_out_q, alu_out_d;
  logic [WORD_SIZE-1:0] mdr_q, mdr_d;

  logic [WORD_SIZE-1:0]  rs_data, rt_data, imm_ext, alu_result;
  logic [5:0]            opcode;
  alu_op_e               alu_op;
  logic                  req_c, we_c;
  logic [ADDR_WIDTH-1:0] addr_c;

  assign opcode  = ir_q[31:26];
  assign imm_ext = {{(WORD_SIZE-16){ir_q[15]}}, ir_q[15:0]};
  assign alu_op  = funct_to_alu(ir_q[5:0]);

  mcp_regfile #(.WORD_SIZE(WORD_SIZE)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (ir_q[25:21]),
    .rd_addr_b (ir_q[20:16]),
    .rd_data_a (rs_data),
    .rd_data_b (rt_data),
    .wr_en     (write_reg_en),
    .wr_addr   (write_reg_addr),
    .wr_data   (write_reg_data)
  );

  // R-type ALU on the latched operands; wraps modulo 2^WORD_SIZE.
  always_comb begin
    alu_result = '0;
    unique case (alu_op)
      AluAdd:  alu_result = a_q + b_q;
      AluSub:  alu_result = a_q - b_q;
      AluAnd:  alu_result = a_q & b_q;
      AluOr:   alu_result = a_q | b_q;
      AluSlt:  alu_result = {{(WORD_SIZE-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: alu_result = '0;
    endcase
  end

  // Next-state, datapath updates and bus/debug outputs per FSM state.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    alu_out_d    = alu_out_q;
    mdr_d        = mdr_q;
    req_c        = 1'b0;
    we_c         = 1'b0;
    addr_c       = pc_q[ADDR_WIDTH-1:0];
    write_reg_en = 1'b0;
    unique case (state_q)
      StFetch: begin
        req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_d    = mem.mem_rdata[31:0];
          pc_d    = pc_q + WORD_SIZE'(4);
          state_d = StDecode;
        end
      end
      StDecode: begin
        a_d       = rs_data;
        b_d       = rt_data;
        // Branch target computed early; pc_q already points past the branch.
        alu_out_d = pc_q + (imm_ext << 2);
        state_d   = opcode_legal(opcode) ? StExecute : StHalt;
      end
      StExecute: begin
        case (opcode)
          OpRtype: begin
            if (alu_op == AluNone) begin
              state_d = StHalt;
            end else begin
              alu_out_d = alu_result;
              state_d   = StWriteback;
            end
          end
          OpAddi: begin
            alu_out_d = a_q + imm_ext;
            state_d   = StWriteback;
          end
          OpLw, OpSw: begin
            alu_out_d = a_q + imm_ext;
            state_d   = StMemory;
          end
          OpBeq: begin
            if (a_q == b_q) pc_d = alu_out_q;
            state_d = StFetch;
          end
`ifdef MCP_BNE_EN
          OpBne: begin
            if (a_q != b_q) pc_d = alu_out_q;
            state_d = StFetch;
          end
`endif
          OpJ: begin
            pc_d    = {pc_q[WORD_SIZE-1:28], ir_q[25:0], 2'b00};
            state_d = StFetch;
          end
          default: state_d = StHalt;
        endcase
      end
      StMemory: begin
        req_c  = 1'b1;
        we_c   = (opcode == OpSw);
        addr_c = alu_out_q[ADDR_WIDTH-1:0];
        if (mem.mem_ready) begin
          if (opcode == OpSw) begin
            state_d = StFetch;
          end else begin
            mdr_d   = mem.mem_rdata;
            state_d = StWriteback;
          end
        end
      end
      StWriteback: begin
        write_reg_en = 1'b1;
        state_d      = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StFetch;
      pc_q      <= WORD_SIZE'(RESET_PC);
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
    end
  end

  // Reset gates the request directly so it drops in the same cycle rst falls.
  assign mem.mem_req   = req_c & rst;
  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = b_q;

  assign prog_count     = pc_q;
  assign instr_opcode   = opcode;
  assign write_reg_addr = (opcode == OpRtype) ? ir_q[15:11] : ir_q[20:16];
  assign write_reg_data = (opcode == OpLw) ? mdr_q : alu_out_q;
  assign halted         = (state_q == StHalt);

endmodule

// File: doc/multicycle_processor.md
MULTICYCLE_PROCESSOR -- requirements
Module: multicycle_processor

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, datapath/register/memory-data width (minimum 32).
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, memory byte-address width; mem_addr is the low ADDR_WIDTH bits of the computed address.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port mem_req  output  1  memory access request, held until accepted.
REQ-007 SHALL have port mem_we  output  1  write enable, valid with mem_req.
REQ-008 SHALL have port mem_addr  output  ADDR_WIDTH  byte address.
REQ-009 SHALL have port mem_wdata  output  WORD_SIZE  store data.
REQ-010 SHALL have port mem_ready  input  1  access complete this cycle (may be high the same cycle mem_req rises).
REQ-011 SHALL have port mem_rdata  input  WORD_SIZE  read data, valid when mem_ready=1 and mem_we=0.
REQ-012 SHALL have port prog_count  output  WORD_SIZE  current PC.
REQ-013 SHALL have port instr_opcode  output  6  IR[31:26].
REQ-014 SHALL have port write_reg_en, write_reg_addr  output  1/5  register write strobe/index.
REQ-015 SHALL have port write_reg_data  output  WORD_SIZE  register write data.
REQ-016 SHALL have port halted  output  1  core stopped on illegal opcode.

Function
REQ-017 SHALL implement FSM FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT; one state per clock unless stalled.
REQ-018 FETCH SHALL drive mem_req=1, mem_we=0, mem_addr=PC; on mem_ready: IR<=mem_rdata, PC<=PC+4, go DECODE; else remain with all outputs stable.
REQ-019 DECODE SHALL latch A<=R[rs], B<=R[rt], ALUOut<=PC+(signext(imm)<<2); illegal opcode -> HALT.
REQ-020 EXECUTE SHALL handle: R-type (funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A signed slt) -> WRITEBACK; addi 0x08 A+signext(imm) -> WRITEBACK; lw 0x23/sw 0x2B ALUOut<=A+signext(imm) -> MEMORY; beq 0x04 PC<=ALUOut if A==B -> FETCH; j 0x02 PC<={PC[31:28],IR[25:0],2'b00} -> FETCH.
REQ-021 Unknown R-type funct SHALL be treated as illegal (HALT from EXECUTE, no write).
REQ-022 MEMORY SHALL drive mem_req=1, mem_addr=ALUOut; lw: mem_we=0, on mem_ready MDR<=mem_rdata -> WRITEBACK; sw: mem_we=1, mem_wdata=B, on mem_ready -> FETCH.
REQ-023 WRITEBACK SHALL pulse write_reg_en for one cycle; dest rd (R-type) or rt (addi/lw); data ALUOut or MDR.
REQ-024 Writes to register 0 SHALL be discarded; R[0] always reads 0; debug write_reg_* still reflect the attempt.
REQ-025 Arithmetic SHALL wrap modulo 2^WORD_SIZE; no overflow trap.
REQ-026 Zero-wait latency SHALL be: R-type/addi 4, lw 5, sw 4, beq/j 3 cycles; each wait cycle adds exactly one.
REQ-027 HALT SHALL be absorbing until reset: halted=1, mem_req=0, PC frozen.

Reset
REQ-028 rst low SHALL immediately: state=FETCH, PC=RESET_PC, IR/A/B/ALUOut/MDR/all registers=0, mem_req=0, write_reg_en=0, halted=0, even mid-access.
REQ-029 First request after rst rises SHALL be a fetch from RESET_PC on the first clock edge.

Configuration
REQ-030 With MCP_BNE_EN defined, opcode 0x05 (bne) SHALL branch when A!=B, timing as beq; undefined, 0x05 SHALL be illegal -> HALT.

Structure
REQ-031 Opcodes, funct codes, ALU control codes and state encodings SHALL live in the shared cpu_constant_library header.
REQ-032 Register file SHALL be sub-module mcp_regfile (2 async read ports, 1 sync write port, async active-low clear).

Verification
REQ-033 rst low during MEMORY wait -> mem_req=0 same cycle, prog_count=RESET_PC; after release first mem_addr=RESET_PC.
REQ-034 addi $1,$0,-5 (0x2001FFFB), zero-wait -> 4th cycle write_reg_en=1, addr=1, data=0xFFFFFFFB.
REQ-035 sw then lw same address, mem_ready delayed 3 cycles each -> mem_req/mem_addr/mem_wdata stable while waiting; lw writes stored value; sw takes 7, lw 8 cycles.
REQ-036 beq equal regs imm=0xFFFE at PC 0x10 -> next fetch 0x0C; unequal -> 0x14.
REQ-037 Opcode 0x3F -> halted=1 after DECODE, no further mem_req, prog_count constant.
REQ-038 bne 0x05 unequal regs: MCP_BNE_EN defined -> branch taken; undefined -> halted=1.
